cache_axi_responder: RTL and testbench

Memory-side responder for the cache's refill and write-back port. It accepts line and word read requests on the `rd_*` channel and returns data as 32-bit beats on `ret_*`. It accepts line and word write requests on the `wr_*` channel and commits them into an internal word-addressed memory after a fixed latency. It sits below the cache in place of the AXI bridge/DRAM, as the system memory model for cache bring-up and regression.

---
 rtl/cache_axi_responder.sv | 187 ++++++++++++++++++
 tb/tb_cache_axi_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_responder.sv
// cache_axi_responder: word-addressed memory model behind the cache refill
// and write-back port. Define RESP_BACKPRESSURE_EN for LFSR-gated read beats.
module cache_axi_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int RD_LAT    = 3,
    parameter int WR_LAT    = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic {W_IDLE, W_BUSY} w_state_t;

    logic [31:0]   mem [MEM_WORDS];
    r_state_t      r_state, r_next;
    w_state_t      w_state, w_next;
    logic [3:0]    r_cnt, w_cnt;
    logic [1:0]    beat;
    logic          r_line, w_line;
    logic [AW-1:0] r_base, w_base, r_idx, rd_idx, wr_idx;
    logic [3:0]    w_strb;
    logic [127:0]  w_data;
    logic [31:0]   data_q;
    logic          rdy_en, rd_acc, wr_acc, beat_en, commit;
    logic          rd_is_line, wr_is_line;
    logic          unused_addr;

    assign unused_addr = ^{rd_addr[31:AW+2], rd_addr[1:0],
                           wr_addr[31:AW+2], wr_addr[1:0]};

    assign rd_is_line = (rd_type == 3'b100);
    assign wr_is_line = (wr_type == 3'b100);
    assign rd_idx = rd_is_line ? {rd_addr[AW+1:4], 2'b00} : rd_addr[AW+1:2];
    assign wr_idx = wr_is_line ? {wr_addr[AW+1:4], 2'b00} : wr_addr[AW+1:2];

    // Writes win over reads; neither starts while the other is in flight.
    assign wr_rdy = rdy_en & (w_state == W_IDLE) & (r_state == R_IDLE);
    assign rd_rdy = wr_rdy & ~wr_req;
    assign rd_acc = rd_req & rd_rdy;
    assign wr_acc = wr_req & wr_rdy;
    assign commit = (w_state == W_BUSY) && (w_cnt == 4'd0);

`ifdef RESP_BACKPRESSURE_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR; bit 0 grants a read beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign beat_en = lfsr[0];
`else
    assign beat_en = 1'b1;
`endif

    // Hold off both request channels until the cycle after reset release.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Read FSM next state and beat outputs.
    always_comb begin
        r_next    = r_state;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (rd_acc) r_next = R_WAIT;
            end
            R_WAIT: begin
                if (r_cnt == 4'd0) r_next = R_BURST;
            end
            R_BURST: begin
                ret_valid = beat_en;
                ret_last  = beat_en & (~r_line | (beat == 2'd3));
                if (ret_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign r_idx    = r_line ? {r_base[AW-1:2], beat} : r_base;
    assign ret_data = ret_valid ? mem[r_idx] : data_q;

    // Read FSM state, latency counter, beat counter and held data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            beat    <= '0;
            r_line  <= 1'b0;
            r_base  <= '0;
            data_q  <= '0;
        end else begin
            r_state <= r_next;
            if (rd_acc) begin
                r_cnt  <= 4'(RD_LAT - 1);
                beat   <= '0;
                r_line <= rd_is_line;
                r_base <= rd_idx;
            end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (ret_valid) begin
                beat   <= beat + 2'd1;
                data_q <= ret_data;
            end
        end
    end

    // Write FSM next state.
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: begin
                if (wr_acc) w_next = W_BUSY;
            end
            W_BUSY: begin
                if (commit) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM state, latency counter and latched request.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            w_line  <= 1'b0;
            w_base  <= '0;
            w_strb  <= '0;
            w_data  <= '0;
        end else begin
            w_state <= w_next;
            if (wr_acc) begin
                w_cnt  <= 4'(WR_LAT - 1);
                w_line <= wr_is_line;
                w_base <= wr_idx;
                w_strb <= wr_wstrb;
                w_data <= wr_data;
            end else if (w_state == W_BUSY && w_cnt != 4'd0) begin
                w_cnt <= w_cnt - 4'd1;
            end
        end
    end

    // Memory array: commits a latched write; a reset drops it.
    always_ff @(posedge clk) begin
        if (resetn && commit) begin
            if (w_line) begin
                mem[{w_base[AW-1:2], 2'd0}] <= w_data[31:0];
                mem[{w_base[AW-1:2], 2'd1}] <= w_data[63:32];
                mem[{w_base[AW-1:2], 2'd2}] <= w_data[95:64];
                mem[{w_base[AW-1:2], 2'd3}] <= w_data[127:96];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (w_strb[b]) mem[w_base][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_axi_responder.sv
// tb_cache_axi_responder: directed and random checks of cache_axi_responder
// against a cycle-level behavioural memory/beat model.
module tb_cache_axi_responder;
    localparam int MEMW = 4096;
    localparam int RDL  = 3;
    localparam int WRL  = 2;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         rd_req = 1'b0;
    logic [2:0]   rd_type = '0;
    logic [31:0]  rd_addr = '0;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req = 1'b0;
    logic [2:0]   wr_type = '0;
    logic [31:0]  wr_addr = '0;
    logic [3:0]   wr_wstrb = '0;
    logic [127:0] wr_data = '0;
    logic         wr_rdy;

    cache_axi_responder #(
        .MEM_WORDS(MEMW),
        .RD_LAT(RDL),
        .WR_LAT(WRL)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .rd_req(rd_req),
        .rd_type(rd_type),
        .rd_addr(rd_addr),
        .rd_rdy(rd_rdy),
        .ret_valid(ret_valid),
        .ret_last(ret_last),
        .ret_data(ret_data),
        .wr_req(wr_req),
        .wr_type(wr_type),
        .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb),
        .wr_data(wr_data),
        .wr_rdy(wr_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        bit          last;
        int          at;
    } beat_t;

    beat_t        rq[$];
    beat_t        nb;
    logic [31:0]  mm [MEMW];
    bit           m_rdy_en = 1'b0;
    bit           w_pend = 1'b0;
    int           w_at = 0;
    bit           w_line_m = 1'b0;
    int           w_idx_m = 0;
    logic [3:0]   w_strb_m = '0;
    logic [127:0] w_data_m = '0;
    logic [31:0]  last_d = '0;
    bit           acc_rd_evt = 1'b0;
    bit           acc_wr_evt = 1'b0;
    bit           ewr, erd, ev;
    int           base;

    int tests = 0;
    int fails = 0;

    logic [31:0] cap_d[$];
    bit          cap_l[$];
    int          cap_c[$];
    bit          rdy_log[int];

    int t_acc, n_w, n_last;
    logic [31:0] ra;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a / 32'd4) % MEMW;
    endfunction

    // Compare DUT outputs with the model, then advance the model one edge.
    always @(negedge clk) begin
        ewr = m_rdy_en && !w_pend && rq.size() == 0;
        erd = ewr && !wr_req;
        chk("wr_rdy", wr_rdy, ewr);
        chk("rd_rdy", rd_rdy, erd);
        rdy_log[cyc] = rd_rdy;
`ifdef RESP_BACKPRESSURE_EN
        ev = ret_valid && rq.size() > 0 && rq[0].at <= cyc;
        chk("ret_valid_unexpected", ret_valid && !ev, 0);
        if (rq.size() > 0 && cyc > rq[0].at + 400) begin
            chk("beat_timeout", 1, 0);
            void'(rq.pop_front());
        end
`else
        ev = rq.size() > 0 && rq[0].at == cyc;
        chk("ret_valid", ret_valid, ev);
`endif
        if (ev) begin
            chk("ret_data", ret_data, rq[0].d);
            chk("ret_last", ret_last, rq[0].last);
            if (ret_valid) begin
                cap_d.push_back(ret_data);
                cap_l.push_back(ret_last);
                cap_c.push_back(cyc);
                last_d = rq[0].d;
            end
            void'(rq.pop_front());
        end else begin
            chk("ret_last_idle", ret_last, 0);
            chk("ret_data_hold", ret_data, last_d);
        end

        acc_wr_evt = wr_req && ewr && resetn;
        acc_rd_evt = rd_req && erd && resetn;
        if (!resetn) begin
            rq.delete();
            w_pend   = 1'b0;
            m_rdy_en = 1'b0;
            last_d   = '0;
        end else begin
            if (w_pend && w_at == cyc + 1) begin
                if (w_line_m) begin
                    for (int i = 0; i < 4; i++)
                        mm[w_idx_m + i] = w_data_m[32*i +: 32];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (w_strb_m[b])
                            mm[w_idx_m][8*b +: 8] = w_data_m[8*b +: 8];
                end
                w_pend = 1'b0;
            end
            if (acc_wr_evt) begin
                w_pend   = 1'b1;
                w_at     = cyc + 1 + WRL;
                w_line_m = (wr_type == 3'b100);
                w_idx_m  = widx(wr_addr);
                if (w_line_m) w_idx_m = w_idx_m - (w_idx_m % 4);
                w_strb_m = wr_wstrb;
                w_data_m = wr_data;
            end
            if (acc_rd_evt) begin
                base = widx(rd_addr);
                if (rd_type == 3'b100) begin
                    base = base - (base % 4);
                    for (int i = 0; i < 4; i++) begin
                        nb.d    = mm[base + i];
                        nb.last = (i == 3);
                        nb.at   = cyc + 1 + RDL + i;
                        rq.push_back(nb);
                    end
                end else begin
                    nb.d    = mm[base];
                    nb.last = 1'b1;
                    nb.at   = cyc + 1 + RDL;
                    rq.push_back(nb);
                end
            end
            m_rdy_en = 1'b1;
        end
    end

    task automatic do_write(input bit line, input logic [31:0] a,
                            input logic [3:0] s, input logic [127:0] d);
        bit got;
        got = 1'b0;
        wr_req   = 1'b1;
        wr_type  = line ? 3'b100 : 3'b010;
        wr_addr  = a;
        wr_wstrb = s;
        wr_data  = d;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            got = acc_wr_evt;
        end
        chk("wr_accept", got, 1);
        wr_req   = 1'b0;
        wr_type  = 3'($urandom);
        wr_addr  = $urandom;
        wr_wstrb = 4'($urandom);
        wr_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_read(input bit line, input logic [31:0] a,
                           output int t);
        bit got;
        got = 1'b0;
        t = -1;
        rd_req  = 1'b1;
        rd_type = line ? 3'b100 : 3'b001;
        rd_addr = a;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            got = acc_rd_evt;
        end
        chk("rd_accept", got, 1);
        t = cyc;
        rd_req  = 1'b0;
        rd_type = 3'($urandom);
        rd_addr = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rq.size() != 0 || w_pend) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", n >= 3000, 0);
        @(posedge clk); #1;
    endtask

    task automatic clr_cap();
        cap_d.delete();
        cap_l.delete();
        cap_c.delete();
    endtask

    task automatic chk_beats(input string nm, input int n,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_count"}, cap_d.size(), n);
        for (int k = 0; k < n && k < cap_d.size(); k++) begin
            chk($sformatf("%s_d%0d", nm, k), cap_d[k], e[k]);
            chk($sformatf("%s_l%0d", nm, k), cap_l[k], k == n - 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ret_valid", ret_valid, 0);
        chk("reset_ret_last", ret_last, 0);
        chk("reset_ret_data", ret_data, 0);
        chk("reset_rd_rdy", rd_rdy, 0);
        chk("reset_wr_rdy", wr_rdy, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 64; i++)
            do_write(1'b1, 32'(i * 16), 4'hF,
                     {$urandom, $urandom, $urandom, $urandom});
        do_write(1'b1, 32'h100, 4'hF,
                 {32'h44, 32'h33, 32'h22, 32'h11});
        wait_idle();

        clr_cap();
        do_read(1'b1, 32'h0000_0104, t_acc);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk_beats("line_read", 4, 32'h11, 32'h22, 32'h33, 32'h44);
`ifndef RESP_BACKPRESSURE_EN
        for (int k = 0; k < 4 && k < cap_c.size(); k++)
            chk($sformatf("line_beat_cyc%0d", k), cap_c[k], t_acc + 3 + k);
        chk("line_rdy_busy", rdy_log[t_acc + 6], 0);
        chk("line_rdy_back", rdy_log[t_acc + 7], 1);
`endif

        do_write(1'b0, 32'h14, 4'hF, {96'h0, 32'hAABB_CCDD});
        do_write(1'b0, 32'h14, 4'b0101, {96'h0, 32'h1122_3344});
        clr_cap();
        do_read(1'b0, 32'h14, t_acc);
        wait_idle();
        chk_beats("strobe", 1, 32'hAA22_CC44, 0, 0, 0);

        clr_cap();
        fork
            do_write(1'b1, 32'h200, 4'hF, {32'h4, 32'h3, 32'h2, 32'h1});
            do_read(1'b1, 32'h200, t_acc);
            begin
                @(negedge clk);
                chk("simul_rd_rdy", rd_rdy, 0);
            end
        join
        wait_idle();
        chk_beats("simul", 4, 32'h1, 32'h2, 32'h3, 32'h4);

        do_write(1'b0, 32'h0001_4000, 4'hF, {96'h0, 32'hDEAD_BEEF});
        clr_cap();
        do_read(1'b0, 32'h0, t_acc);
        wait_idle();
        chk_beats("wrap", 1, 32'hDEAD_BEEF, 0, 0, 0);

        clr_cap();
        do_read(1'b1, 32'h100, t_acc);
        n_w = 0;
        while (cap_d.size() < 2 && n_w < 300) begin
            @(posedge clk); #1;
            n_w++;
        end
        chk("rst_burst_beat1", cap_d.size() >= 2, 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_burst_valid", ret_valid, 0);
        chk("rst_burst_rd_rdy", rd_rdy, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_release_rd_rdy0", rd_rdy, 0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_release_rd_rdy1", rd_rdy, 1);
        @(posedge clk); #1;
        clr_cap();
        do_read(1'b1, 32'h200, t_acc);
        wait_idle();
        chk_beats("after_rst", 4, 32'h1, 32'h2, 32'h3, 32'h4);

        do_write(1'b0, 32'h30, 4'hF, {96'h0, 32'h1234_5678});
        wait_idle();
        do_write(1'b0, 32'h30, 4'hF, {96'h0, 32'hCAFE_F00D});
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr_cap();
        do_read(1'b0, 32'h30, t_acc);
        wait_idle();
        chk_beats("rst_write", 1, 32'h1234_5678, 0, 0, 0);

        clr_cap();
        for (int k = 0; k < 100; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 1023));
                do_write($urandom_range(0, 1) == 1, ra, 4'($urandom),
                         {$urandom, $urandom, $urandom, $urandom});
            end
            ra = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 1023));
            do_read(1'b1, ra, t_acc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        chk("rand_beats", cap_d.size(), 400);
        n_last = 0;
        foreach (cap_l[k]) if (cap_l[k]) n_last++;
        chk("rand_lasts", n_last, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
